// File: rtl/resp_checker_pkg.sv
// Shared types and constants for the response checker.
// The MISR constants are used only when RESP_CHECKER_MISR_EN is defined.
package resp_checker_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam int unsigned MISR_W    = 16;
    // x^16 + x^12 + x^5 + 1, with the x^16 term implied by the shift-out.
    localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;
    localparam logic [MISR_W-1:0] MISR_SEED = 16'hFFFF;

    // Truncated to the index width at the point of use.
    localparam logic [31:0] ERR_IDX_NONE = '1;

    function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] cur,
                                                    input logic [MISR_W-1:0] din);
        logic [MISR_W-1:0] shifted;
        shifted = {cur[MISR_W-2:0], 1'b0} ^ (cur[MISR_W-1] ? MISR_POLY : '0);
        return shifted ^ din;
    endfunction

endpackage

// File: rtl/resp_checker_if.sv
// Sample/result bundle between the vector source and the response checker.
// The sig field exists only when RESP_CHECKER_MISR_EN is defined.
interface resp_checker_if #(
    parameter int unsigned OUT_W = 3,
    parameter int unsigned CNT_W = 8
);

    logic             start;
    logic             smp_valid;
    logic [OUT_W-1:0] dut_out;
    logic [OUT_W-1:0] exp_out;

    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] vec_idx;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] first_err_idx;
    logic [OUT_W-1:0] err_bits;
`ifdef RESP_CHECKER_MISR_EN
    logic [15:0]      sig;
`endif

    modport master (
        output start, smp_valid, dut_out, exp_out,
        input  busy, done, pass, vec_idx, err_cnt, first_err_idx, err_bits
`ifdef RESP_CHECKER_MISR_EN
        , input sig
`endif
    );

    modport slave (
        input  start, smp_valid, dut_out, exp_out,
        output busy, done, pass, vec_idx, err_cnt, first_err_idx, err_bits
`ifdef RESP_CHECKER_MISR_EN
        , output sig
`endif
    );

endinterface

// File: rtl/resp_misr.sv
// 16-bit MISR signature over a narrow data word, zero-extended.
// Clear reloads the seed and takes priority over enable.
module resp_misr
    import resp_checker_pkg::*;
#(
    parameter int unsigned DW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DW-1:0]     data,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] sig_q;
    logic [MISR_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = MISR_SEED;
        end else if (en) begin
            sig_d = misr_next(sig_q, MISR_W'(data));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= MISR_SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/resp_checker.sv
// Response checker: counts vectors and mismatches over a fixed-length run, then reports pass.
// Define RESP_CHECKER_MISR_EN to add a 16-bit MISR signature of the captured outputs.
module resp_checker
    import resp_checker_pkg::*;
#(
    parameter int unsigned OUT_W   = 3,
    parameter int unsigned NUM_VEC = 5,
    parameter int unsigned CNT_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    resp_checker_if.slave  bus
);

    localparam logic [CNT_W-1:0] IDX_NONE = CNT_W'(ERR_IDX_NONE);
    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(NUM_VEC - 1);

    state_e           state_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [CNT_W-1:0] vec_idx_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] first_err_q;
    logic [OUT_W-1:0] err_bits_q;

    logic [OUT_W-1:0] diff;
    logic             mismatch;
    logic             accept;
    logic             launch;
    logic             last_vec;
    logic [CNT_W-1:0] err_cnt_inc;

    always_comb begin
        diff        = bus.dut_out ^ bus.exp_out;
        // Case inequality so an X/Z on the DUT side is reported as a mismatch in simulation.
        mismatch    = (bus.dut_out !== bus.exp_out);
        accept      = (state_q == StRun) && bus.smp_valid;
        launch      = (state_q != StRun) && bus.start;
        last_vec    = (vec_idx_q == IDX_LAST);
        err_cnt_inc = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            vec_idx_q   <= '0;
            err_cnt_q   <= '0;
            first_err_q <= IDX_NONE;
            err_bits_q  <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    // A sample arriving with start is dropped; the run begins next cycle.
                    if (bus.start) begin
                        state_q     <= StRun;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        vec_idx_q   <= '0;
                        err_cnt_q   <= '0;
                        first_err_q <= IDX_NONE;
                        err_bits_q  <= '0;
                    end
                end
                StRun: begin
                    if (bus.smp_valid) begin
                        vec_idx_q <= vec_idx_q + CNT_W'(1);
                        if (mismatch) begin
                            err_cnt_q  <= err_cnt_inc;
                            err_bits_q <= err_bits_q | diff;
                            if (err_cnt_q == '0) begin
                                first_err_q <= vec_idx_q;
                            end
                        end
                        if (last_vec) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_cnt_q == '0) && !mismatch;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.vec_idx       = vec_idx_q;
    assign bus.err_cnt       = err_cnt_q;
    assign bus.first_err_idx = first_err_q;
    assign bus.err_bits      = err_bits_q;

`ifdef RESP_CHECKER_MISR_EN
    resp_misr #(
        .DW (OUT_W)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .clr  (launch),
        .en   (accept),
        .data (bus.dut_out),
        .sig  (bus.sig)
    );
`else
    logic unused_ctl;
    assign unused_ctl = launch ^ accept;
`endif

endmodule

// File: tb/tb_resp_checker.sv
// Randomized scoreboard bench for resp_checker; checks sig when RESP_CHECKER_MISR_EN is defined.
module tb_resp_checker;

    localparam int NV = 5;

    typedef logic [2:0] vec_t [NV];

    typedef struct {
        int          errs;
        int          first;
        logic [2:0]  bits;
        bit          pass;
        logic [15:0] sig;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    resp_checker_if #(.OUT_W(3), .CNT_W(8)) bus ();

    resp_checker #(
        .OUT_W   (3),
        .NUM_VEC (NV),
        .CNT_W   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t last_exp;
    exp_t mon_exp;
    bit   done_d = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Signature as polynomial division: shift in one bit, reduce modulo the 17-bit generator.
    function automatic logic [15:0] ref_misr(input logic [15:0] s, input logic [2:0] d);
        logic [16:0] t;
        t = {s, 1'b0};
        if (t[16]) t = t ^ 17'h11021;
        return t[15:0] ^ {13'b0, d};
    endfunction

    function automatic exp_t model(input vec_t d, input vec_t e);
        exp_t r;
        r.errs  = 0;
        r.first = 255;
        r.bits  = 3'b000;
        r.sig   = 16'hFFFF;
        for (int i = 0; i < NV; i++) begin
            if (d[i] !== e[i]) begin
                if (r.errs == 0) r.first = i;
                r.errs = (r.errs < 255) ? r.errs + 1 : 255;
                r.bits = r.bits | (d[i] ^ e[i]);
            end
            r.sig = ref_misr(r.sig, d[i]);
        end
        r.pass = (r.errs == 0);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one result popped per rising edge of done.
    always @(negedge clk) begin
        if (bus.done === 1'b1 && !done_d) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_done: actual=done required=no_result_pending");
            end else begin
                mon_exp = exp_q.pop_front();
                chk("sb_err_cnt", bus.err_cnt, mon_exp.errs);
                chk("sb_first_err_idx", bus.first_err_idx, mon_exp.first);
                chk("sb_err_bits", bus.err_bits, mon_exp.bits);
                chk("sb_pass", bus.pass, mon_exp.pass);
                chk("sb_vec_idx", bus.vec_idx, NV);
                chk("sb_busy", bus.busy, 0);
`ifdef RESP_CHECKER_MISR_EN
                chk("sb_sig", bus.sig, mon_exp.sig);
`endif
            end
        end
        done_d = (bus.done === 1'b1);
    end

    task automatic chk_cleared(input string tag, input logic busy_req);
        chk({tag, "_busy"}, bus.busy, busy_req);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_pass"}, bus.pass, 0);
        chk({tag, "_vec_idx"}, bus.vec_idx, 0);
        chk({tag, "_err_cnt"}, bus.err_cnt, 0);
        chk({tag, "_first_err_idx"}, bus.first_err_idx, 8'hFF);
        chk({tag, "_err_bits"}, bus.err_bits, 0);
`ifdef RESP_CHECKER_MISR_EN
        chk({tag, "_sig"}, bus.sig, 16'hFFFF);
`endif
    endtask

    task automatic run(input vec_t d, input vec_t e, input int maxgap,
                       input bit start_valid, input bit mid_start);
        exp_t r;
        r = model(d, e);
        exp_q.push_back(r);
        last_exp = r;

        bus.start     = 1'b1;
        bus.smp_valid = start_valid;
        bus.dut_out   = ~e[0];
        bus.exp_out   = e[0];
        tick();
        bus.start     = 1'b0;
        bus.smp_valid = 1'b0;
        chk_cleared("run_start", 1'b1);

        for (int i = 0; i < NV; i++) begin
            repeat ($urandom_range(maxgap, 0)) begin
                bus.dut_out = 3'($urandom);
                bus.exp_out = 3'($urandom);
                tick();
            end
            if (mid_start && i == 2) begin
                bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
                chk("start_in_run_vec_idx", bus.vec_idx, 2);
                chk("start_in_run_busy", bus.busy, 1);
            end
            bus.smp_valid = 1'b1;
            bus.dut_out   = d[i];
            bus.exp_out   = e[i];
            tick();
            bus.smp_valid = 1'b0;
        end

        chk("done_latency", bus.done, 1);
        tick();
        chk("sb_drained", exp_q.size(), 0);

        // Junk samples in DONE must not move anything.
        repeat (2) begin
            bus.smp_valid = 1'b1;
            bus.dut_out   = 3'b111;
            bus.exp_out   = 3'b000;
            tick();
            bus.smp_valid = 1'b0;
        end
        chk("frozen_done", bus.done, 1);
        chk("frozen_busy", bus.busy, 0);
        chk("frozen_vec_idx", bus.vec_idx, NV);
        chk("frozen_err_cnt", bus.err_cnt, last_exp.errs);
        chk("frozen_first_err_idx", bus.first_err_idx, last_exp.first);
        chk("frozen_err_bits", bus.err_bits, last_exp.bits);
        chk("frozen_pass", bus.pass, last_exp.pass);
`ifdef RESP_CHECKER_MISR_EN
        chk("frozen_sig", bus.sig, last_exp.sig);
`endif
    endtask

    vec_t exp_base = '{3'b010, 3'b110, 3'b000, 3'b011, 3'b111};
    vec_t dut_err  = '{3'b010, 3'b110, 3'b100, 3'b011, 3'b101};
    vec_t rd;
    vec_t re;

    initial begin
        bus.start     = 1'b0;
        bus.smp_valid = 1'b0;
        bus.dut_out   = 3'b000;
        bus.exp_out   = 3'b000;
        rst           = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_cleared("reset", 1'b0);

        // Samples in IDLE are ignored.
        repeat (3) begin
            bus.smp_valid = 1'b1;
            bus.dut_out   = 3'b101;
            bus.exp_out   = 3'b010;
            tick();
        end
        bus.smp_valid = 1'b0;
        chk_cleared("idle_ignore", 1'b0);

        // Reset in the middle of a run discards it.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (2) begin
            bus.smp_valid = 1'b1;
            bus.dut_out   = 3'b001;
            bus.exp_out   = 3'b000;
            tick();
        end
        bus.smp_valid = 1'b0;
        chk("midrun_vec_idx", bus.vec_idx, 2);
        chk("midrun_err_cnt", bus.err_cnt, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_cleared("midrun_reset", 1'b0);

        run(exp_base, exp_base, 0, 1'b0, 1'b0);
        run(dut_err, exp_base, 3, 1'b1, 1'b1);
        run(exp_base, exp_base, 2, 1'b1, 1'b0);

        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < NV; i++) begin
                re[i] = 3'($urandom);
                rd[i] = ($urandom_range(3, 0) == 0) ? 3'($urandom) : re[i];
            end
            run(rd, re, 3, 1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
